btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce_ch.sv | 101 ++++++++++
 rtl/btn_conditioner.sv | 35 +++
 tb/tb_btn_conditioner.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - channel indices, default timing constants and counter width helper for the button conditioner
package btn_pkg;

    localparam int BTN_U = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_C = 3;

    localparam int NUM_BTN_DEFAULT         = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int REPEAT_DELAY_DEFAULT    = 50000000;
    localparam int REPEAT_PERIOD_DEFAULT   = 20000000;

    // Width of a counter that must be able to hold n-1 with headroom.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: 2-FF synchroniser, debounce counter, level, press pulse, optional auto-repeat (BTN_REPEAT_EN)
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             press;
    logic             rep_fire;

    // A change is accepted once the synchronised input has differed from level for DEBOUNCE_CYCLES edges.
    assign accept = (sync2 != level) && (cnt == CNT_MAX);
    assign press  = accept && sync2;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce counter: any return to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_N = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W = cnt_width(RPT_N);

    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rpt_max;
    logic             repeating;
    logic             releasing;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; a release on this edge cancels it.
    assign releasing = accept && !sync2;
    assign rpt_max   = repeating ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    assign rep_fire  = level && !releasing && (rcnt == rpt_max);

    // Repeat counter runs only while the debounced level is held high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt      <= '0;
            repeating <= 1'b0;
        end else if (press || !level) begin
            rcnt      <= '0;
            repeating <= 1'b0;
        end else if (rep_fire) begin
            rcnt      <= '0;
            repeating <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_unused
    end
`endif

    // Pulse is rebuilt every edge, so it can never stretch past one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= press || rep_fire;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounces NUM_BTN push buttons into levels and press pulses (auto-repeat with BTN_REPEAT_EN)
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               any_pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    // Combinational OR of registered pulses keeps any_pulse aligned with btn_pulse.
    assign any_pulse = |btn_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - table-driven bench for btn_conditioner with short debounce and repeat timing
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int NB = 4;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic          any_pulse;

    int errors = 0;
    int checks = 0;

    btn_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .any_pulse (any_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] pls;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [NB-1:0] raw, input logic [NB-1:0] lvl,
                       input logic [NB-1:0] pls, input int n);
        vec_t v;
        v.rst = r;
        v.raw = raw;
        v.lvl = lvl;
        v.pls = pls;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [NB-1:0] act,
                         input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0d: actual=%b expected=%b", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulse_edges[$];
        int exp_edges[$];
        int hold;

        // 1: reset held three edges, then idle
        add(1, 4'b0000, 4'b0000, 4'b0000, 3);
        add(0, 4'b0000, 4'b0000, 4'b0000, 20);
        // 2: btnL pressed 10 edges, accepted on 6th, released and cleared on 6th after release
        add(0, 4'b0010, 4'b0000, 4'b0000, 5);
        add(0, 4'b0010, 4'b0010, 4'b0010, 1);
        add(0, 4'b0010, 4'b0010, 4'b0000, 4);
        add(0, 4'b0000, 4'b0010, 4'b0000, 5);
        add(0, 4'b0000, 4'b0000, 4'b0000, 3);
        // 3: btnC bounces 1,0,1,0 then holds; pulse 6 edges after final rise
        add(0, 4'b1000, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1000, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, 4'b1000, 4'b0000, 4'b0000, 5);
        add(0, 4'b1000, 4'b1000, 4'b1000, 1);
        add(0, 4'b1000, 4'b1000, 4'b0000, 2);
        add(0, 4'b0000, 4'b1000, 4'b0000, 5);
        add(0, 4'b0000, 4'b0000, 4'b0000, 3);
        // 4: U and R together, then C while both held
        add(0, 4'b0101, 4'b0000, 4'b0000, 5);
        add(0, 4'b0101, 4'b0101, 4'b0101, 1);
        add(0, 4'b0101, 4'b0101, 4'b0000, 2);
        add(0, 4'b1101, 4'b0101, 4'b0000, 2);
        add(0, 4'b1000, 4'b0101, 4'b0000, 3);
        add(0, 4'b1000, 4'b1101, 4'b1000, 1);
        add(0, 4'b1000, 4'b1101, 4'b0000, 1);
        add(0, 4'b0000, 4'b1000, 4'b0000, 5);
        add(0, 4'b0000, 4'b0000, 4'b0000, 3);
        // 5: btnR held, reset at cnt=2, press re-detected after reset release
        add(0, 4'b0100, 4'b0000, 4'b0000, 4);
        add(1, 4'b0100, 4'b0000, 4'b0000, 1);
        add(0, 4'b0100, 4'b0000, 4'b0000, 5);
        add(0, 4'b0100, 4'b0100, 4'b0100, 1);
        add(0, 4'b0000, 4'b0100, 4'b0000, 5);
        add(0, 4'b0000, 4'b0000, 4'b0000, 3);

        check("reset_level", -1, btn_level, 4'b0000);
        check("reset_pulse", -1, btn_pulse, 4'b0000);
        check("reset_any", -1, {3'b000, any_pulse}, 4'b0000);

        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            btn_raw = vecs[i].raw;
            step();
            check("level", i, btn_level, vecs[i].lvl);
            check("pulse", i, btn_pulse, vecs[i].pls);
            check("any_pulse", i, {3'b000, any_pulse}, {3'b000, |vecs[i].pls});
        end

        // 6: long hold on btnL; pulses only from the press (plus repeats when enabled)
`ifdef BTN_REPEAT_EN
        hold = 30;
        exp_edges = '{6, 16, 21, 26, 31};
`else
        hold = 40;
        exp_edges = '{6};
`endif
        rst = 1'b0;
        for (int e = 1; e <= hold + 15; e++) begin
            btn_raw = (e <= hold) ? (4'b1 << BTN_L) : 4'b0000;
            step();
            if (btn_pulse[BTN_L]) pulse_edges.push_back(e);
            if (btn_pulse[BTN_U] || btn_pulse[BTN_R] || btn_pulse[BTN_C])
                check("hold_other_pulse", e, btn_pulse, 4'b0000);
        end
        check("hold_pulse_count", 0, 4'(pulse_edges.size()), 4'(exp_edges.size()));
        foreach (exp_edges[i]) begin
            if (i < pulse_edges.size())
                check("hold_pulse_edge", i, 4'(pulse_edges[i]), 4'(exp_edges[i]));
        end
        check("hold_release_level", 0, btn_level, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
